mac_kbd_serial: RTL

MAC_KBD_SERIAL -- requirements
Module: mac_kbd_serial

---
 rtl/mac_kbd_pkg.sv | 21 ++
 rtl/kbd_bitclk.sv | 69 ++++++
 rtl/mac_kbd_serial.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mac_kbd_pkg.sv
// Shared state encoding and default bit-timing constants for the Mac keyboard serial link.
package mac_kbd_pkg;

  localparam int unsigned PHASE_W = 16;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [PHASE_W-1:0] CLK_LOW_DEF  = 16'd160;
  localparam logic [PHASE_W-1:0] CLK_HIGH_DEF = 16'd170;
  localparam logic [PHASE_W-1:0] REQ_CYC_DEF  = 16'd8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX      = 3'd1,
    S_CMD     = 3'd2,
    S_WAIT    = 3'd3,
    S_TX      = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

endpackage

// File: rtl/kbd_bitclk.sv
// Eight-bit keyboard clock generator: each bit is CLK_LOW ce-cycles low then CLK_HIGH high.
// Rise/fall/done pulses mark the ce-cycle whose edge changes the clock (or ends the byte).
module kbd_bitclk
  import mac_kbd_pkg::*;
#(
  parameter logic [PHASE_W-1:0] CLK_LOW  = CLK_LOW_DEF,
  parameter logic [PHASE_W-1:0] CLK_HIGH = CLK_HIGH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic i_start,
  input  logic i_en,
  output logic o_kbd_clk,
  output logic o_rise_c,
  output logic o_fall_c,
  output logic o_done_c,
  output logic o_last_c
);

  logic [PHASE_W-1:0] r_phase;
  logic [BIT_W-1:0]   r_bit;
  logic               r_clk;
  logic               r_run;
  logic               w_step;

  // A phase ends only while enabled and not being reloaded.
  assign w_step    = ce && i_en && !i_start && r_run && (r_phase == '0);
  assign o_last_c  = (r_bit == '1);
  assign o_rise_c  = w_step && !r_clk;
  assign o_fall_c  = w_step && r_clk && !o_last_c;
  assign o_done_c  = w_step && r_clk && o_last_c;
  assign o_kbd_clk = r_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clk   <= 1'b1;
      r_run   <= 1'b0;
      r_phase <= '0;
      r_bit   <= '0;
    end else if (ce) begin
      if (i_start) begin
        r_clk   <= 1'b0;
        r_run   <= 1'b1;
        r_phase <= CLK_LOW - PHASE_W'(1);
        r_bit   <= '0;
      end else if (!i_en) begin
        r_clk   <= 1'b1;
        r_run   <= 1'b0;
        r_phase <= '0;
        r_bit   <= '0;
      end else if (r_run) begin
        if (r_phase != '0) begin
          r_phase <= r_phase - PHASE_W'(1);
        end else if (!r_clk) begin
          r_clk   <= 1'b1;
          r_phase <= CLK_HIGH - PHASE_W'(1);
        end else if (o_last_c) begin
          r_run <= 1'b0;
        end else begin
          r_clk   <= 1'b0;
          r_bit   <= r_bit + BIT_W'(1);
          r_phase <= CLK_LOW - PHASE_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/mac_kbd_serial.sv
// Keyboard side of the Mac VIA shift-register link: clocks in a host command,
// hands it to the translator, then clocks the translator's response back out.
module mac_kbd_serial
  import mac_kbd_pkg::*;
#(
  parameter logic [PHASE_W-1:0] CLK_LOW  = CLK_LOW_DEF,
  parameter logic [PHASE_W-1:0] CLK_HIGH = CLK_HIGH_DEF,
  parameter logic [PHASE_W-1:0] REQ_CYC  = REQ_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              host_data,
  input  logic              host_oe,
  output logic              kbd_clk,
  output logic              kbd_data,
  output logic [BYTE_W-1:0] data_out,
  output logic              strobe_out,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              strobe_in
);

  state_e             r_state, w_state_n;
  logic [PHASE_W-1:0] r_req, w_req_n;
  logic [BYTE_W-1:0]  r_shift, w_shift_n;
  logic [BYTE_W-1:0]  r_tx, w_tx_n;
  logic [BYTE_W-1:0]  r_data_out, w_data_out_n;
  logic               r_kbd_data, w_kbd_data_n;
  logic               r_strobe, w_strobe_n;
  logic               w_host_low, w_req_hit, w_start, w_en;
  logic               w_rise, w_fall, w_done, w_last;

  assign w_host_low = host_oe && !host_data;
  assign w_req_hit  = w_host_low && (r_req == REQ_CYC - PHASE_W'(1));
  assign w_en       = (r_state == S_RX) || (r_state == S_TX);

  kbd_bitclk #(
    .CLK_LOW  (CLK_LOW),
    .CLK_HIGH (CLK_HIGH)
  ) u_bitclk (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .i_start   (w_start),
    .i_en      (w_en),
    .o_kbd_clk (kbd_clk),
    .o_rise_c  (w_rise),
    .o_fall_c  (w_fall),
    .o_done_c  (w_done),
    .o_last_c  (w_last)
  );

  // Next state and next registered outputs; the request counter restarts on every state change.
  always_comb begin
    w_state_n    = r_state;
    w_req_n      = '0;
    w_shift_n    = r_shift;
    w_tx_n       = r_tx;
    w_data_out_n = r_data_out;
    w_kbd_data_n = r_kbd_data;
    w_strobe_n   = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_hit) begin
          w_state_n = S_RX;
          w_start   = 1'b1;
        end else if (w_host_low) begin
          w_req_n = r_req + PHASE_W'(1);
        end
      end
      S_RX: begin
        if (w_rise) begin
          w_shift_n = {r_shift[BYTE_W-2:0], host_data};
          if (w_last) begin
            w_state_n    = S_CMD;
            w_data_out_n = {r_shift[BYTE_W-2:0], host_data};
            w_strobe_n   = 1'b1;
          end
        end
      end
      S_CMD: w_state_n = S_WAIT;
      S_WAIT: begin
        if (strobe_in) begin
          w_state_n    = S_TX;
          w_start      = 1'b1;
          w_kbd_data_n = data_in[BYTE_W-1];
          w_tx_n       = {data_in[BYTE_W-2:0], 1'b0};
        end else if (w_req_hit) begin
          w_state_n = S_RX;
          w_start   = 1'b1;
        end else if (w_host_low) begin
          w_req_n = r_req + PHASE_W'(1);
        end
      end
      S_TX: begin
        if (w_fall) begin
          w_kbd_data_n = r_tx[BYTE_W-1];
          w_tx_n       = {r_tx[BYTE_W-2:0], 1'b0};
        end else if (w_done) begin
          w_kbd_data_n = 1'b1;
          w_state_n    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!w_host_low) w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_data_out <= '0;
      r_kbd_data <= 1'b1;
      r_strobe   <= 1'b0;
    end else if (ce) begin
      r_state    <= w_state_n;
      r_req      <= w_req_n;
      r_shift    <= w_shift_n;
      r_tx       <= w_tx_n;
      r_data_out <= w_data_out_n;
      r_kbd_data <= w_kbd_data_n;
      r_strobe   <= w_strobe_n;
    end
  end

  assign kbd_data   = r_kbd_data;
  assign data_out   = r_data_out;
  assign strobe_out = r_strobe;

endmodule
